// File: rtl/parity_frame_checker.sv
// Serial frame parity checker/generator: FRAME_BITS data bits plus one parity bit
// per frame, per-frame even/odd selection, saturating error counter.
module parity_frame_checker #(
  parameter int FRAME_BITS = 8,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             odd_sel,
  input  logic             abort,
  output logic             y,
  output logic             busy,
  output logic             frame_done,
  output logic             parity_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = ($clog2(FRAME_BITS + 1) < 1) ? 1 : $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_mode;
  logic             r_y;
  logic             r_busy;
  logic             r_done;
  logic             r_perr;
  logic [ERR_W-1:0] r_err_count;

  logic w_acc_next;
  logic w_err;
  logic w_last_data;

  assign w_acc_next  = r_acc ^ x;
  assign w_err       = r_acc ^ x ^ r_mode;
  assign w_last_data = (r_cnt == CNT_W'(FRAME_BITS - 1));

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_mode      <= 1'b0;
      r_y         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        // Abort wins over a valid bit; in IDLE these clears change nothing.
        r_state <= IDLE;
        r_cnt   <= '0;
        r_acc   <= 1'b0;
        r_y     <= 1'b0;
        r_busy  <= 1'b0;
      end else if (x_valid) begin
        unique case (r_state)
          IDLE: begin
            r_mode  <= odd_sel;
            r_acc   <= x;
            r_cnt   <= CNT_W'(1);
            r_y     <= x ^ odd_sel;
            r_busy  <= 1'b1;
            r_state <= (FRAME_BITS == 1) ? PAR : DATA;
          end
          DATA: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            r_y   <= w_acc_next ^ r_mode;
            if (w_last_data) r_state <= PAR;
          end
          PAR: begin
            r_done <= 1'b1;
            r_perr <= w_err;
            if (w_err && (r_err_count != {ERR_W{1'b1}}))
              r_err_count <= r_err_count + ERR_W'(1);
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_y     <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign y          = r_y;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign parity_err = r_perr;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: three instances (8/8, 8/2, 1/8 bits)
// share stimulus; the selected one is driven and compared against a reference model.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, x_valid, x, odd_sel, abort;
  int   sel;

  logic va, vb, vc, aa, ab, ac;
  always_comb begin
    va = x_valid && (sel == 0);
    vb = x_valid && (sel == 1);
    vc = x_valid && (sel == 2);
    aa = abort && (sel == 0);
    ab = abort && (sel == 1);
    ac = abort && (sel == 2);
  end

  logic a_y, a_busy, a_done, a_perr;
  logic b_y, b_busy, b_done, b_perr;
  logic c_y, c_busy, c_done, c_perr;
  logic [7:0] a_ec, c_ec;
  logic [1:0] b_ec;

  parity_frame_checker #(.FRAME_BITS(8), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .x_valid(va), .x(x), .odd_sel(odd_sel), .abort(aa),
    .y(a_y), .busy(a_busy), .frame_done(a_done), .parity_err(a_perr), .err_count(a_ec));
  parity_frame_checker #(.FRAME_BITS(8), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .x_valid(vb), .x(x), .odd_sel(odd_sel), .abort(ab),
    .y(b_y), .busy(b_busy), .frame_done(b_done), .parity_err(b_perr), .err_count(b_ec));
  parity_frame_checker #(.FRAME_BITS(1), .ERR_W(8)) dut_c (
    .clk(clk), .rst(rst), .x_valid(vc), .x(x), .odd_sel(odd_sel), .abort(ac),
    .y(c_y), .busy(c_busy), .frame_done(c_done), .parity_err(c_perr), .err_count(c_ec));

  typedef struct packed {
    logic       y;
    logic       busy;
    logic       done;
    logic       perr;
    logic [7:0] ec;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int   m_fb, m_emax, m_k, m_ec;
  logic m_in, m_acc, m_mode, m_y, m_perr, m_done;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    case (sel)
      0:       o = '{a_y, a_busy, a_done, a_perr, a_ec};
      1:       o = '{b_y, b_busy, b_done, b_perr, {6'd0, b_ec}};
      default: o = '{c_y, c_busy, c_done, c_perr, c_ec};
    endcase
    return o;
  endfunction

  task automatic model_reset(input int fb, input int emax);
    m_fb = fb; m_emax = emax;
    m_in = 0; m_k = 0; m_acc = 0; m_mode = 0; m_y = 0; m_perr = 0; m_done = 0; m_ec = 0;
  endtask

  task automatic model_step(input logic v, input logic xb, input logic os, input logic abt);
    logic err;
    m_done = 0;
    if (abt) begin
      m_in = 0; m_k = 0; m_acc = 0; m_y = 0;
    end else if (v) begin
      if (!m_in || m_k < m_fb) begin
        if (!m_in) begin
          m_in = 1; m_mode = os; m_acc = 0; m_k = 0;
        end
        m_acc = m_acc ^ xb;
        m_k++;
        m_y = m_acc ^ m_mode;
      end else begin
        err = m_acc ^ xb ^ m_mode;
        m_done = 1;
        m_perr = err;
        if (err && m_ec < m_emax) m_ec++;
        m_in = 0; m_k = 0; m_acc = 0; m_y = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic xb, input logic os, input logic abt);
    obs_t e, o;
    x_valid = v; x = xb; odd_sel = os; abort = abt;
    model_step(v, xb, os, abt);
    exp_q.push_back('{m_y, m_in, m_done, m_perr, m_ec[7:0]});
    @(posedge clk);
    #1;
    x_valid = 1'b0; abort = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      o = observe();
      check("y", o.y, e.y);
      check("busy", o.busy, e.busy);
      check("frame_done", o.done, e.done);
      check("parity_err", o.perr, e.perr);
      check("err_count", o.ec, e.ec);
    end
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n, input logic os,
                            input logic par, input int maxgap);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) step(1'b0, 1'b0, os, 1'b0);
      step(1'b1, bits[n-1-i], os, 1'b0);
    end
    step(1'b1, par, os, 1'b0);
  endtask

  task automatic do_reset(input int fb, input int emax);
    obs_t o;
    rst = 1'b1;
    #1;
    o = observe();
    check("rst_outputs", o, '0);
    model_reset(fb, emax);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    obs_t o;
    int   ey[4];
    logic [7:0] d3;
    int   ec_exp[5];
    rst = 1'b1; x_valid = 0; x = 0; odd_sel = 0; abort = 0; sel = 0;
    @(posedge clk);
    #1;

    // Instance A: FRAME_BITS=8, ERR_W=8
    sel = 0;
    do_reset(8, 255);
    send_frame(8'b10110000, 8, 1'b0, 1'b1, 0);
    o = observe();
    check("t1_perr", o.perr, 1'b0);
    check("t1_ec", o.ec, 8'd0);

    send_frame(8'b10110000, 8, 1'b1, 1'b1, 0);
    o = observe();
    check("t2_perr", o.perr, 1'b1);
    check("t2_ec", o.ec, 8'd1);
    send_frame(8'b10110000, 8, 1'b1, 1'b0, 0);
    o = observe();
    check("t2b_perr", o.perr, 1'b0);
    check("t2b_ec", o.ec, 8'd1);

    // y tracking with gaps: data 1,1,0,1 even -> y 1,0,0,1
    ey = '{1, 0, 0, 1};
    d3 = 8'b11010000;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, d3[7-i], 1'b0, 1'b0);
      if (i < 4) begin
        o = observe();
        check($sformatf("t3_y%0d", i), o.y, ey[i][0]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    o = observe();
    check("t3_done", o.done, 1'b1);
    check("t3_perr", o.perr, 1'b0);

    for (int f = 0; f < 4; f++)
      send_frame(8'($urandom), 8, 1'($urandom), 1'($urandom), 3);

    // Abort after 5 data bits
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    o = observe();
    check("t4_busy", o.busy, 1'b0);
    check("t4_y", o.y, 1'b0);
    check("t4_done", o.done, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'b10110000, 8, 1'b1, 1'b0, 2);
    o = observe();
    check("t4_after_perr", o.perr, 1'b0);

    // Instance B: ERR_W=2 saturation, then mid-frame reset
    sel = 1;
    do_reset(8, 3);
    ec_exp = '{1, 2, 3, 3, 3};
    for (int f = 0; f < 5; f++) begin
      send_frame(8'b10110000, 8, 1'b0, 1'b0, 1);
      o = observe();
      check($sformatf("t5_ec%0d", f), o.ec, 8'(ec_exp[f]));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    o = observe();
    check("t5_busy_pre", o.busy, 1'b1);
    do_reset(8, 3);
    send_frame(8'b00000001, 8, 1'b0, 1'b1, 0);

    // Instance C: FRAME_BITS=1 back-to-back, odd_sel toggled on parity bit
    sel = 2;
    do_reset(1, 255);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    o = observe();
    check("t6_f0_done", o.done, 1'b1);
    check("t6_f0_perr", o.perr, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    o = observe();
    check("t6_f1_nodone", o.done, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    o = observe();
    check("t6_f1_perr", o.perr, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    o = observe();
    check("t6_f2_perr", o.perr, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    o = observe();
    check("t6_f3_perr", o.perr, 1'b1);
    check("t6_ec", o.ec, 8'd2);
    for (int i = 0; i < 12; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
